jacobi_result_drain: RTL and testbench
======================================

Name: jacobi_result_drain

Overview:
- Downstream consumer of the Jacobi 5-point solver's result stream.
- Captures one full (M+2)x(M+2) grid frame, presented word-by-word on the solver's data/valid/done outputs, into a local buffer.
- Computes interior-cell statistics (sum, max) during capture.
- Replays the frame to a host-side sink over a ready/valid stream with backpressure, row/col tags and a last marker.

Parameters:
- M, 4, interior grid dimension; the frame is (M+2)x(M+2) words including the boundary.
- MEM_SIZE, (M+2)*(M+2), words per frame.
- DATA_W, 32, word width; Q8.24 fixed point, treated as unsigned.
- SUM_W, 48, width of the interior sum accumulator.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_data  in  DATA_W  solver result word.
- in_valid  in  1  in_data is valid this cycle; no backpressure is possible upstream.
- in_done  in  1  solver signals end of frame.
- out_data  out  DATA_W  replayed grid word.
- out_valid  out  1  out_data, out_row, out_col and out_last are valid.
- out_ready  in  1  sink accepts the current word.
- out_last  out  1  current word is frame word MEM_SIZE-1.
- out_row  out  8  row index of the current word.
- out_col  out  8  column index of the current word.
- interior_sum  out  SUM_W  sum of interior words (1<=row,col<=M) of the last complete frame.
- interior_max  out  DATA_W  maximum interior word of the last complete frame.
- stats_valid  out  1  interior_sum and interior_max are valid.
- busy  out  1  state is not IDLE.
- err_short  out  1  sticky: in_done arrived before MEM_SIZE words were received.
- err_overflow  out  1  sticky: in_valid arrived while in DRAIN; the word is dropped.

Behaviour:
- Reset (synchronous, rst=1 at posedge): state=IDLE; all outputs 0; wr_cnt, rd_cnt, row/col counters and accumulators cleared. Buffer contents are not cleared (don't care). Reset mid-frame abandons the frame with no partial output.
- States: IDLE, CAPTURE, DRAIN.
- IDLE, in_valid=1:
  - write in_data to buf[0]; wr_cnt=1;
  - sum=in_data if that cell is interior, else 0 (for M>=1, word 0 is boundary, so 0); max likewise;
  - clear err_short, err_overflow and stats_valid; go to CAPTURE.
  - in_done alone in IDLE is ignored.
- CAPTURE, in_valid=1:
  - write buf[wr_cnt]; wr_cnt++;
  - maintain row/col counters (col wraps at M+1 -> 0, row++) instead of dividing.
  - Interior words: sum += zero-extended word; max updated when word > max (unsigned compare).
  - When the word written is index MEM_SIZE-1: stats_valid<=1, interior_* latched, next state DRAIN.
- CAPTURE, in_done=1 with wr_cnt<MEM_SIZE (including the cycle's own valid word): err_short<=1, return to IDLE, stats_valid stays 0, no drain.
- in_done in the same cycle as the final (MEM_SIZE-th) word: frame is complete, no error.
- DRAIN, read side:
  - Buffer read is registered; out_valid rises 1 cycle after entering DRAIN, with word 0, row=0, col=0.
  - A transfer occurs on out_valid&&out_ready. The next word is presented the following cycle, so full throughput of 1 word/cycle when out_ready is held high.
  - While out_valid=1 && out_ready=0: out_data, out_row, out_col and out_last are held stable.
  - out_last=1 only with word MEM_SIZE-1.
  - The transfer of the last word drops out_valid the next cycle and returns to IDLE.
  - stats_valid and interior_* remain held until the next capture starts.
- DRAIN, input side:
  - in_valid=1: err_overflow<=1, word discarded, drain continues unaffected.
  - in_done is ignored.
- IDLE entered with in_valid=1 on the same cycle DRAIN completes: the word is captured as the first of a new frame (same as the IDLE rule).
- Arithmetic:
  - sum wraps modulo 2^SUM_W; for M<=16, 32-bit words cannot reach the wrap.
  - out_row and out_col are zero-extended counters; the design requires M+1<=255.
- Frame latency from the final input word to first out_valid: 2 cycles.

Test Plan:
- M=4: stream 36 words of value i<<24 (i = index), in_valid continuously high, out_ready=1 -> 36 outputs in order with row/col matching i/6 and i%6, out_last only at i=35. interior_sum = sum of interior i (i in {7..10,13..16,19..22,25..28}, total 280) <<24; interior_max=28<<24; stats_valid=1.
- Same frame with out_ready toggled 1/0 every cycle -> identical output sequence; outputs held stable during ready-low cycles; no word lost or duplicated.
- Send 20 words then assert in_done -> err_short=1, state returns to IDLE, out_valid never asserted. The next full frame clears err_short and drains normally.
- During DRAIN, drive in_valid for 3 cycles -> err_overflow=1, drained data unchanged, flag cleared on the next capture start.
- Assert rst at capture word 17 and again mid-drain -> all outputs 0 the next cycle. A fresh 36-word frame afterwards drains correctly.
- Interior words 0xFFFFFFFF (all 16) -> interior_sum=16*0xFFFFFFFF with no truncation; interior_max=0xFFFFFFFF.

Source files
------------

// File: rtl/jacobi_result_drain.sv
// Captures one (M+2)x(M+2) Jacobi result frame, accumulates interior statistics,
// then replays the frame over a ready/valid stream tagged with row/col/last.
module jacobi_result_drain #(
  parameter int M        = 4,
  parameter int MEM_SIZE = (M + 2) * (M + 2),
  parameter int DATA_W   = 32,
  parameter int SUM_W    = 48
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_done,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic [7:0]        out_row,
  output logic [7:0]        out_col,
  output logic [SUM_W-1:0]  interior_sum,
  output logic [DATA_W-1:0] interior_max,
  output logic              stats_valid,
  output logic              busy,
  output logic              err_short,
  output logic              err_overflow
);

  localparam int ADDR_W = $clog2(MEM_SIZE);
  localparam int CNT_W  = $clog2(MEM_SIZE + 1);
  localparam logic [7:0]       EDGE_IDX = 8'(M + 1);
  localparam logic [7:0]       M_IDX    = 8'(M);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(MEM_SIZE - 1);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2
  } state_t;

  state_t            state_r;
  logic [DATA_W-1:0] buf_r [MEM_SIZE];
  logic [CNT_W-1:0]  wr_cnt_r;
  logic [CNT_W-1:0]  rd_cnt_r;
  logic [7:0]        cap_row_r;
  logic [7:0]        cap_col_r;
  logic [7:0]        drn_row_r;
  logic [7:0]        drn_col_r;
  logic [SUM_W-1:0]  acc_sum_r;
  logic [DATA_W-1:0] acc_max_r;

  logic              interior_s;
  logic              last_xfer_s;
  logic              start_s;
  logic              load_s;
  logic              wr_en_s;
  logic [CNT_W-1:0]  wr_addr_s;
  logic [SUM_W-1:0]  sum_next_s;
  logic [DATA_W-1:0] max_next_s;

  // Control decode and running-statistics update for the word being captured.
  always_comb begin
    interior_s  = (cap_row_r >= 8'd1) && (cap_row_r <= M_IDX) &&
                  (cap_col_r >= 8'd1) && (cap_col_r <= M_IDX);
    last_xfer_s = (state_r == DRAIN) && out_valid && out_ready && out_last;
    // A word arriving as the drain retires its last beat opens the next frame.
    start_s     = in_valid && ((state_r == IDLE) || last_xfer_s);
    load_s      = (state_r == DRAIN) && (!out_valid || (out_ready && !out_last));
    wr_en_s     = start_s || ((state_r == CAPTURE) && in_valid);
    if (start_s) begin
      wr_addr_s = {CNT_W{1'b0}};
    end else begin
      wr_addr_s = wr_cnt_r;
    end
    if (interior_s) begin
      sum_next_s = acc_sum_r + {{(SUM_W - DATA_W){1'b0}}, in_data};
      max_next_s = (in_data > acc_max_r) ? in_data : acc_max_r;
    end else begin
      sum_next_s = acc_sum_r;
      max_next_s = acc_max_r;
    end
  end

  // Frame buffer write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      buf_r[wr_addr_s[ADDR_W-1:0]] <= in_data;
    end
  end

  // Capture/drain state machine with registered stream and status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      busy         <= 1'b0;
      wr_cnt_r     <= {CNT_W{1'b0}};
      rd_cnt_r     <= {CNT_W{1'b0}};
      cap_row_r    <= 8'd0;
      cap_col_r    <= 8'd0;
      drn_row_r    <= 8'd0;
      drn_col_r    <= 8'd0;
      acc_sum_r    <= {SUM_W{1'b0}};
      acc_max_r    <= {DATA_W{1'b0}};
      out_data     <= {DATA_W{1'b0}};
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      out_row      <= 8'd0;
      out_col      <= 8'd0;
      interior_sum <= {SUM_W{1'b0}};
      interior_max <= {DATA_W{1'b0}};
      stats_valid  <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else if (start_s) begin
      state_r      <= CAPTURE;
      busy         <= 1'b1;
      wr_cnt_r     <= ONE_CNT;
      cap_row_r    <= 8'd0;
      cap_col_r    <= 8'd1;
      acc_sum_r    <= {SUM_W{1'b0}};
      acc_max_r    <= {DATA_W{1'b0}};
      out_valid    <= 1'b0;
      out_last     <= 1'b0;
      interior_sum <= {SUM_W{1'b0}};
      interior_max <= {DATA_W{1'b0}};
      stats_valid  <= 1'b0;
      err_short    <= 1'b0;
      err_overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          busy <= 1'b0;
        end
        CAPTURE: begin
          if (in_valid) begin
            wr_cnt_r  <= wr_cnt_r + ONE_CNT;
            acc_sum_r <= sum_next_s;
            acc_max_r <= max_next_s;
            if (cap_col_r == EDGE_IDX) begin
              cap_col_r <= 8'd0;
              cap_row_r <= cap_row_r + 8'd1;
            end else begin
              cap_col_r <= cap_col_r + 8'd1;
            end
            if (wr_cnt_r == LAST_IDX) begin
              state_r      <= DRAIN;
              stats_valid  <= 1'b1;
              interior_sum <= sum_next_s;
              interior_max <= max_next_s;
              rd_cnt_r     <= {CNT_W{1'b0}};
              drn_row_r    <= 8'd0;
              drn_col_r    <= 8'd0;
            end else if (in_done) begin
              state_r   <= IDLE;
              busy      <= 1'b0;
              err_short <= 1'b1;
            end
          end else if (in_done) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            err_short <= 1'b1;
          end
        end
        DRAIN: begin
          if (in_valid) begin
            err_overflow <= 1'b1;
          end
          if (last_xfer_s) begin
            state_r   <= IDLE;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
          end else if (load_s) begin
            out_data  <= buf_r[rd_cnt_r[ADDR_W-1:0]];
            out_row   <= drn_row_r;
            out_col   <= drn_col_r;
            out_last  <= (rd_cnt_r == LAST_IDX);
            out_valid <= 1'b1;
            rd_cnt_r  <= rd_cnt_r + ONE_CNT;
            if (drn_col_r == EDGE_IDX) begin
              drn_col_r <= 8'd0;
              drn_row_r <= drn_row_r + 8'd1;
            end else begin
              drn_col_r <= drn_col_r + 8'd1;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jacobi_result_drain.sv
// Randomized scoreboard bench for jacobi_result_drain: the driver pushes expected
// replay words and frame statistics, an independent monitor pops and compares.
module tb_jacobi_result_drain;

  localparam int M = 4;
  localparam int W = M + 2;
  localparam int N = W * W;

  logic        clk;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_done;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        out_last;
  logic [7:0]  out_row;
  logic [7:0]  out_col;
  logic [47:0] interior_sum;
  logic [31:0] interior_max;
  logic        stats_valid;
  logic        busy;
  logic        err_short;
  logic        err_overflow;

  jacobi_result_drain #(.M(M)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_done(in_done),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .out_row(out_row), .out_col(out_col), .interior_sum(interior_sum),
    .interior_max(interior_max), .stats_valid(stats_valid), .busy(busy),
    .err_short(err_short), .err_overflow(err_overflow)
  );

  typedef struct packed {
    logic [31:0] d;
    logic [7:0]  r;
    logic [7:0]  c;
    logic        last;
  } exp_t;

  typedef struct packed {
    logic [47:0] sum;
    logic [31:0] max;
  } stat_t;

  exp_t        exp_q[$];
  stat_t       stat_q[$];
  logic [31:0] frame_w [N];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          rdy_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Sink readiness pattern, changed just after each rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(1, 0));
      endcase
    end
  end

  // Reference model: a complete frame replays in index order; stats cover interior cells.
  task automatic push_frame();
    stat_t s;
    exp_t  e;
    s.sum = 48'd0;
    s.max = 32'd0;
    for (int i = 0; i < N; i++) begin
      e.d    = frame_w[i];
      e.r    = 8'(i / W);
      e.c    = 8'(i % W);
      e.last = (i == N - 1);
      exp_q.push_back(e);
      if ((i / W) >= 1 && (i / W) <= M && (i % W) >= 1 && (i % W) <= M) begin
        s.sum = s.sum + 48'(frame_w[i]);
        if (frame_w[i] > s.max) s.max = frame_w[i];
      end
    end
    stat_q.push_back(s);
  endtask

  // Monitor: compare every accepted word, and check hold-stability under backpressure.
  logic        hold_pend = 1'b0;
  logic [48:0] hold_val;
  always @(negedge clk) begin
    exp_t  e;
    stat_t s;
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend) begin
        check("hold_stable", 64'({out_valid, out_data, out_row, out_col, out_last}),
              64'({1'b1, hold_val}));
        hold_pend = 1'b0;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_word", 64'({out_row, out_col, out_data}), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("out_data", 64'(out_data), 64'(e.d));
          check("out_row_col", 64'({out_row, out_col}), 64'({e.r, e.c}));
          check("out_last", 64'(out_last), 64'(e.last));
          if (e.r == 8'd0 && e.c == 8'd0 && stat_q.size() != 0) begin
            s = stat_q.pop_front();
            check("stats_valid", 64'(stats_valid), 64'd1);
            check("interior_sum", 64'(interior_sum), 64'(s.sum));
            check("interior_max", 64'(interior_max), 64'(s.max));
          end
        end
      end else if (out_valid) begin
        hold_pend = 1'b1;
        hold_val  = {out_data, out_row, out_col, out_last};
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_stream_zero"}, 64'({out_valid, out_last, out_row, out_col, out_data}), 64'd0);
    check({tag, "_stats_zero"}, 64'({stats_valid, interior_max}), 64'd0);
    check({tag, "_sum_zero"}, 64'(interior_sum), 64'd0);
    check({tag, "_flags_zero"}, 64'({busy, err_short, err_overflow}), 64'd0);
  endtask

  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    in_done  = 1'b0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete();
    stat_q.delete();
    check_all_zero(tag);
    rst = 1'b0;
  endtask

  // Drive nwords of frame_w; optionally pulse in_done afterwards or reset at word rst_at.
  task automatic send_frame(input int nwords, input bit short_done, input int rst_at,
                            input int gap_pct);
    for (int i = 0; i < nwords; i++) begin
      if (i == 1) begin
        check("start_flags", 64'({busy, stats_valid, err_short, err_overflow}), 64'b1000);
      end
      if (i == rst_at) begin
        do_reset("rst_capture");
        return;
      end
      while (gap_pct > 0 && $urandom_range(99, 0) < gap_pct) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
      end
      in_valid = 1'b1;
      in_data  = frame_w[i];
      @(posedge clk);
      #1;
      if (i == N - 1) push_frame();
    end
    in_valid = 1'b0;
    if (short_done) begin
      in_done = 1'b1;
      @(posedge clk);
      #1;
      in_done = 1'b0;
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 500; k++) begin
      if (exp_q.size() == 0 && !busy) break;
      @(posedge clk);
      #1;
    end
    check("drain_complete", 64'({exp_q.size() == 0, busy}), 64'b10);
  endtask

  task automatic fill_random();
    for (int i = 0; i < N; i++) frame_w[i] = $urandom;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_done  = 1'b0;
    in_data  = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;

    // Ramp frame, full throughput.
    for (int i = 0; i < N; i++) frame_w[i] = 32'(i) << 24;
    rdy_mode = 0;
    send_frame(N, 1'b0, -1, 0);
    wait_drain();
    check("ramp_sum_const", 64'(interior_sum), 64'h0000_0001_1800_0000);
    check("ramp_max_const", 64'(interior_max), 64'h1C00_0000);

    // Same frame with ready toggling every cycle.
    rdy_mode = 1;
    send_frame(N, 1'b0, -1, 0);
    wait_drain();
    rdy_mode = 0;

    // Short frame: no drain, error latched, cleared by next frame start.
    fill_random();
    send_frame(20, 1'b1, -1, 0);
    repeat (3) @(posedge clk);
    #1;
    check("short_flags", 64'({err_short, busy, stats_valid, out_valid}), 64'b1000);
    fill_random();
    send_frame(N, 1'b0, -1, 0);
    wait_drain();

    // Overflow words during drain are dropped and flagged.
    fill_random();
    send_frame(N, 1'b0, -1, 0);
    for (int k = 0; k < 50 && !out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    check("drain_started", 64'(out_valid), 64'd1);
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = $urandom;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    wait_drain();
    check("err_overflow_set", 64'(err_overflow), 64'd1);
    fill_random();
    send_frame(N, 1'b0, -1, 0);
    wait_drain();

    // Reset mid-capture, then mid-drain, then a clean frame.
    fill_random();
    send_frame(N, 1'b0, 17, 0);
    fill_random();
    send_frame(N, 1'b0, -1, 0);
    for (int k = 0; k < 100 && exp_q.size() > 25; k++) begin
      @(posedge clk);
      #1;
    end
    do_reset("rst_drain");
    fill_random();
    send_frame(N, 1'b0, -1, 0);
    wait_drain();

    // Saturated interior: sum must not truncate.
    fill_random();
    for (int r = 1; r <= M; r++)
      for (int c = 1; c <= M; c++) frame_w[r * W + c] = 32'hFFFF_FFFF;
    send_frame(N, 1'b0, -1, 0);
    wait_drain();
    check("ff_sum_const", 64'(interior_sum), 64'h0000_000F_FFFF_FFF0);
    check("ff_max_const", 64'(interior_max), 64'hFFFF_FFFF);

    // Random frames with input gaps and random backpressure.
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      fill_random();
      send_frame(N, 1'b0, -1, 25);
      wait_drain();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
